node_tree_emitter: RTL
======================

Name: node_tree_emitter

Overview:
- Serializer in the opposite direction to the node tree lookup: takes a stream of tree nodes and emits a flat field-id token stream.
- Each node carries a field id, a tree depth and a group/leaf flag. The block tracks open groups on an internal stack and inserts END tokens wherever the depth decreases.
- Sits between the node producer and the field-id transmit path. The output token stream is what the field-id lookup consumes when it rebuilds the tree.

Parameters:
- ID_W, 8, width of a field id
- MAX_DEPTH, 8, maximum number of simultaneously open groups (stack entries)
- DEPTH_W, $clog2(MAX_DEPTH+1), width of depth fields

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous reset, active-low
- node_valid  in  1  input node valid
- node_rdy  out  1  input node accepted when node_valid && node_rdy
- node_field_id  in  ID_W  field id of the node
- node_depth  in  DEPTH_W  depth of the node (0 = child of root)
- node_is_group  in  1  1 = group node (opens a level), 0 = leaf
- node_flush  in  1  1 = end of message; field_id/depth/is_group are ignored
- field_id_valid  out  1  output token valid
- field_id_rdy  in  1  downstream ready
- field_id_o  out  ID_W  token field id
- field_kind_o  out  2  token kind: 00 FIELD, 01 START, 10 END, 11 MSG_END
- cur_depth_o  out  DEPTH_W  number of currently open groups
- err_o  out  1  one-cycle pulse on a rejected node

Behaviour:
- Reset (async assert, sync release):
  - field_id_valid=0, field_id_o=0, field_kind_o=00, cur_depth_o=0, err_o=0.
  - State IDLE; stack pointer 0; stack contents don't-care.
- Output stage: single register. field_id_valid holds, with field_id_o and field_kind_o stable, until field_id_rdy is seen. A token is loaded only when the slot is empty or is draining that cycle ("slot free").
- node_rdy = (state==IDLE) && slot free. It is combinational from state and field_id_rdy.
- Accepting node (d = node_depth, cur = cur_depth_o) in IDLE:
  - flush: if cur>0, go to CLOSE with target 0 and pending MSG_END. If cur==0, load MSG_END (id 0) next cycle and stay IDLE.
  - d > cur: error. Pulse err_o next cycle, emit no token, stack unchanged.
  - is_group && d == MAX_DEPTH: overflow error, same handling as d > cur.
  - d == cur: load the token next cycle (latency 1). Kind is START if group, else FIELD; id is node_field_id. A group pushes its id (cur+1); a leaf leaves cur unchanged.
  - d < cur: latch the node and go to CLOSE with target d.
- CLOSE state:
  - On each cycle the slot is free, load END with id = stack[top], pop, and decrement cur.
  - When cur reaches the target on a pop, the next free-slot cycle loads the latched node token (START/FIELD with push rules, or MSG_END) and returns to IDLE.
  - For k pops with field_id_rdy held high: END tokens appear on cycles N+1..N+k and the node token on N+k+1.
- cur_depth_o updates in the same cycle as each push or pop, so it is registered and matches the last token loaded.
- Downstream stall (field_id_rdy=0) freezes CLOSE progress. No token is dropped or duplicated.
- node_rdy stays 0 throughout CLOSE. Nodes are never reordered.
- Reset mid-CLOSE or with valid held: all state is cleared immediately and the pending token is discarded.
- err_o is never asserted together with a token load caused by the same node.

Test Plan:
- Flat leaves:
  - Stimulus: nodes (id 3,d0,leaf), (id 5,d0,leaf), rdy=1.
  - Required: FIELD 3 at N+1, FIELD 5 at N+2; cur_depth stays 0; node_rdy stays 1.
- Nesting and unwind:
  - Stimulus: (7,d0,grp), (9,d1,grp), (4,d2,leaf), (2,d0,leaf).
  - Required: START 7, START 9, FIELD 4, END 9, END 7, FIELD 2; cur_depth 1,2,2,1,0,0; node_rdy low for 2 cycles during CLOSE.
- Flush:
  - Stimulus: after (7,d0,grp),(9,d1,grp), send flush.
  - Required: END 9, END 7, MSG_END 0; cur_depth 0.
  - Also: flush at depth 0 gives a single MSG_END at N+1.
- Errors:
  - At cur=0, send (6,d2,leaf): err_o pulses 1 cycle, no token.
  - Fill MAX_DEPTH=8 groups, then send (1,d8,grp): err_o pulses, cur stays 8.
- Backpressure:
  - Stimulus: during the nesting scenario, hold field_id_rdy=0 for 5 cycles at each token.
  - Required: identical token sequence; each token held stable while stalled; no loss.
- Async reset:
  - Stimulus: assert reset_i=0 mid-CLOSE (cur=2, one END pending).
  - Required: field_id_valid=0 and cur_depth_o=0 immediately. After release, (3,d0,leaf) gives FIELD 3 with no stale END.

Source files
------------

// File: rtl/node_tree_emitter.sv
// Turns a stream of (field id, depth, group/leaf) tree nodes into a flat token stream,
// inserting END tokens on depth decrease and MSG_END on flush.
module node_tree_emitter #(
  parameter int ID_W      = 8,
  parameter int MAX_DEPTH = 8,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               node_valid,
  output logic               node_rdy,
  input  logic [ID_W-1:0]    node_field_id,
  input  logic [DEPTH_W-1:0] node_depth,
  input  logic               node_is_group,
  input  logic               node_flush,
  output logic               field_id_valid,
  input  logic               field_id_rdy,
  output logic [ID_W-1:0]    field_id_o,
  output logic [1:0]         field_kind_o,
  output logic [DEPTH_W-1:0] cur_depth_o,
  output logic               err_o,
  output logic               dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && rdy; once
  // field_id_valid is high the token is held stable until field_id_rdy is seen.

  localparam logic [1:0] K_FIELD   = 2'b00;
  localparam logic [1:0] K_START   = 2'b01;
  localparam logic [1:0] K_END     = 2'b10;
  localparam logic [1:0] K_MSG_END = 2'b11;
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_CLOSE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               tok_valid_q, tok_valid_d;
  logic [ID_W-1:0]    tok_id_q, tok_id_d;
  logic [1:0]         tok_kind_q, tok_kind_d;
  logic [DEPTH_W-1:0] cur_q, cur_d;
  logic               err_q, err_d;
  logic [DEPTH_W-1:0] tgt_q, tgt_d;
  logic [ID_W-1:0]    lat_id_q, lat_id_d;
  logic               lat_grp_q, lat_grp_d;
  logic               lat_flush_q, lat_flush_d;

  logic [ID_W-1:0]    stack_q [MAX_DEPTH];
  logic               push_en;
  logic [DEPTH_W-1:0] push_idx;
  logic [ID_W-1:0]    push_val;

  logic               slot_free;
  logic [DEPTH_W-1:0] cur_m1;
  logic [ID_W-1:0]    top_id;

  assign slot_free = !tok_valid_q || field_id_rdy;
  assign node_rdy  = (state_q == S_IDLE) && slot_free;
  assign cur_m1    = cur_q - 1'b1;
  assign top_id    = (cur_q != '0) ? stack_q[cur_m1] : '0;

  always_comb begin
    state_d     = state_q;
    tok_valid_d = tok_valid_q && !field_id_rdy;
    tok_id_d    = tok_id_q;
    tok_kind_d  = tok_kind_q;
    cur_d       = cur_q;
    err_d       = 1'b0;
    tgt_d       = tgt_q;
    lat_id_d    = lat_id_q;
    lat_grp_d   = lat_grp_q;
    lat_flush_d = lat_flush_q;
    push_en     = 1'b0;
    push_idx    = cur_q;
    push_val    = '0;

    case (state_q)
      S_IDLE: begin
        if (node_valid && node_rdy) begin
          if (node_flush && cur_q == '0) begin
            tok_valid_d = 1'b1;
            tok_id_d    = '0;
            tok_kind_d  = K_MSG_END;
          end else if (node_flush || node_depth < cur_q) begin
            // First END goes out on the accepting edge; CLOSE handles the rest.
            tok_valid_d = 1'b1;
            tok_id_d    = top_id;
            tok_kind_d  = K_END;
            cur_d       = cur_m1;
            tgt_d       = node_flush ? '0 : node_depth;
            lat_id_d    = node_field_id;
            lat_grp_d   = node_is_group;
            lat_flush_d = node_flush;
            state_d     = S_CLOSE;
          end else if (node_depth > cur_q || (node_is_group && node_depth == MAX_D)) begin
            err_d = 1'b1;
          end else begin
            tok_valid_d = 1'b1;
            tok_id_d    = node_field_id;
            tok_kind_d  = node_is_group ? K_START : K_FIELD;
            if (node_is_group) begin
              push_en  = 1'b1;
              push_val = node_field_id;
              cur_d    = cur_q + 1'b1;
            end
          end
        end
      end
      S_CLOSE: begin
        if (slot_free) begin
          tok_valid_d = 1'b1;
          if (cur_q != tgt_q) begin
            tok_id_d   = top_id;
            tok_kind_d = K_END;
            cur_d      = cur_m1;
          end else begin
            state_d = S_IDLE;
            if (lat_flush_q) begin
              tok_id_d   = '0;
              tok_kind_d = K_MSG_END;
            end else begin
              tok_id_d   = lat_id_q;
              tok_kind_d = lat_grp_q ? K_START : K_FIELD;
              if (lat_grp_q) begin
                push_en  = 1'b1;
                push_val = lat_id_q;
                cur_d    = cur_q + 1'b1;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      tok_valid_q <= 1'b0;
      tok_id_q    <= '0;
      tok_kind_q  <= K_FIELD;
      cur_q       <= '0;
      err_q       <= 1'b0;
      tgt_q       <= '0;
      lat_id_q    <= '0;
      lat_grp_q   <= 1'b0;
      lat_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tok_valid_q <= tok_valid_d;
      tok_id_q    <= tok_id_d;
      tok_kind_q  <= tok_kind_d;
      cur_q       <= cur_d;
      err_q       <= err_d;
      tgt_q       <= tgt_d;
      lat_id_q    <= lat_id_d;
      lat_grp_q   <= lat_grp_d;
      lat_flush_q <= lat_flush_d;
    end
  end

  // Stack contents need no reset: entries above the pointer are never read.
  always_ff @(posedge clk_i) begin
    if (push_en) stack_q[push_idx[$clog2(MAX_DEPTH)-1:0]] <= push_val;
  end

  assign field_id_valid = tok_valid_q;
  assign field_id_o     = tok_id_q;
  assign field_kind_o   = tok_kind_q;
  assign cur_depth_o    = cur_q;
  assign err_o          = err_q;
  assign dbg_state_o    = state_q;

endmodule
